// File: rtl/mms_pkg.sv
// Shared constants and the strict-compare winner rule for the max/min selector tree.
package mms_pkg;

    localparam logic MMS_SEL_MAX = 1'b0;
    localparam logic MMS_SEL_MIN = 1'b1;

    // Operands are widened to this many bits before comparing, so WIDTH may not exceed it.
    localparam int MMS_MAX_W = 64;

    function automatic logic mms_upper_wins(
        input logic                 sel,
        input logic [MMS_MAX_W-1:0] lo,
        input logic [MMS_MAX_W-1:0] hi,
        input logic                 signed_mode
    );
        logic gt_s;
        logic lt_s;
        if (signed_mode) begin
            gt_s = ($signed(hi) > $signed(lo));
            lt_s = ($signed(hi) < $signed(lo));
        end else begin
            gt_s = (hi > lo);
            lt_s = (hi < lo);
        end
        case (sel)
            MMS_SEL_MAX: return gt_s;
            MMS_SEL_MIN: return lt_s;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mms_cmp_stage.sv
// One tree level: pairwise reduce of N_IN {value, index} candidates into N_IN/2 winners,
// registered together with the set's valid and select bits.
module mms_cmp_stage
    import mms_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int N_IN   = 2,
    parameter int IDXW   = 1,
    parameter bit SIGNED = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          in_valid,
    input  logic                          in_select,
    input  logic [N_IN*WIDTH-1:0]         in_value,
    input  logic [N_IN*IDXW-1:0]          in_index,
    output logic                          out_valid,
    output logic                          out_select,
    output logic [(N_IN/2)*WIDTH-1:0]     out_value,
    output logic [(N_IN/2)*IDXW-1:0]      out_index
);

    localparam int N_OUT = N_IN / 2;

    logic [N_OUT*WIDTH-1:0] win_value_s;
    logic [N_OUT*IDXW-1:0]  win_index_s;
    logic                   valid_r;
    logic                   select_r;
    logic [N_OUT*WIDTH-1:0] value_r;
    logic [N_OUT*IDXW-1:0]  index_r;

    function automatic logic [MMS_MAX_W-1:0] ext_value(input logic [WIDTH-1:0] v);
        if (SIGNED) begin
            return MMS_MAX_W'($signed(v));
        end else begin
            return MMS_MAX_W'(v);
        end
    endfunction

    // Pairwise reduce; ties keep the lower (even) candidate.
    always_comb begin
        win_value_s = '0;
        win_index_s = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (mms_upper_wins(in_select,
                               ext_value(in_value[(2*j)*WIDTH +: WIDTH]),
                               ext_value(in_value[(2*j+1)*WIDTH +: WIDTH]),
                               SIGNED)) begin
                win_value_s[j*WIDTH +: WIDTH] = in_value[(2*j+1)*WIDTH +: WIDTH];
                win_index_s[j*IDXW +: IDXW]   = in_index[(2*j+1)*IDXW +: IDXW];
            end else begin
                win_value_s[j*WIDTH +: WIDTH] = in_value[(2*j)*WIDTH +: WIDTH];
                win_index_s[j*IDXW +: IDXW]   = in_index[(2*j)*IDXW +: IDXW];
            end
        end
    end

    // Stage register: loads on the global advance, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r  <= 1'b0;
            select_r <= 1'b0;
            value_r  <= '0;
            index_r  <= '0;
        end else if (en) begin
            valid_r  <= in_valid;
            select_r <= in_select;
            value_r  <= win_value_s;
            index_r  <= win_index_s;
        end else begin
            valid_r  <= valid_r;
            select_r <= select_r;
            value_r  <= value_r;
            index_r  <= index_r;
        end
    end

    assign out_valid  = valid_r;
    assign out_select = select_r;
    assign out_value  = value_r;
    assign out_index  = index_r;

endmodule

// File: rtl/mms_tree_pipe.sv
// Pipelined max/min selector over NUM operands: LVL registered compare levels under a
// single global advance, returning the extreme value, its operand index and its select.
module mms_tree_pipe
    import mms_pkg::*;
#(
    parameter int  WIDTH  = 8,
    parameter int  NUM    = 8,
    parameter bit  SIGNED = 1'b0,
    localparam int LVL    = $clog2(NUM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_select,
    input  logic [NUM*WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic [LVL-1:0]       out_index,
    output logic                 out_select
);

    // Candidates of all levels packed back to back: level k starts at 2*NUM - 2*(NUM>>k).
    localparam int TOT = 2*NUM - 1;

    logic [TOT*WIDTH-1:0] cand_value_s;
    logic [TOT*LVL-1:0]   cand_index_s;
    logic [LVL:0]         lvl_valid_s;
    logic [LVL:0]         lvl_select_s;
    logic                 advance_s;

    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    assign cand_value_s[NUM*WIDTH-1:0] = in_data;
    assign lvl_valid_s[0]              = in_valid;
    assign lvl_select_s[0]             = in_select;

    for (genvar i = 0; i < NUM; i++) begin : idx0_g
        assign cand_index_s[i*LVL +: LVL] = LVL'(i);
    end

    for (genvar k = 0; k < LVL; k++) begin : lvl_g
        localparam int N_IN    = NUM >> k;
        localparam int OFF_IN  = 2*NUM - 2*N_IN;
        localparam int OFF_OUT = 2*NUM - N_IN;

        mms_cmp_stage #(
            .WIDTH  (WIDTH),
            .N_IN   (N_IN),
            .IDXW   (LVL),
            .SIGNED (SIGNED)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (advance_s),
            .in_valid   (lvl_valid_s[k]),
            .in_select  (lvl_select_s[k]),
            .in_value   (cand_value_s[OFF_IN*WIDTH +: N_IN*WIDTH]),
            .in_index   (cand_index_s[OFF_IN*LVL +: N_IN*LVL]),
            .out_valid  (lvl_valid_s[k+1]),
            .out_select (lvl_select_s[k+1]),
            .out_value  (cand_value_s[OFF_OUT*WIDTH +: (N_IN/2)*WIDTH]),
            .out_index  (cand_index_s[OFF_OUT*LVL +: (N_IN/2)*LVL])
        );
    end

    assign out_valid  = lvl_valid_s[LVL];
    assign out_select = lvl_select_s[LVL];
    assign out_result = cand_value_s[(TOT-1)*WIDTH +: WIDTH];
    assign out_index  = cand_index_s[(TOT-1)*LVL +: LVL];

endmodule

// File: tb/tb_mms_tree_pipe.sv
// Self-checking bench: an unsigned and a signed instance share one input stream and are
// checked against directed vectors and a linear-scan reference model.
module tb_mms_tree_pipe;

    localparam int W = 8;
    localparam int N = 8;
    localparam int L = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_select = 1'b0;
    logic [63:0]  in_data = '0;
    logic         out_ready = 1'b1;

    logic         in_ready_u, out_valid_u, out_select_u;
    logic [W-1:0] out_result_u;
    logic [L-1:0] out_index_u;
    logic         in_ready_s, out_valid_s, out_select_s;
    logic [W-1:0] out_result_s;
    logic [L-1:0] out_index_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int in_cnt = 0;
    int out_cnt = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic       sel;
        logic [7:0] ru;
        logic [2:0] iu;
        logic [7:0] rs;
        logic [2:0] isg;
    } exp_t;

    typedef struct {
        logic        sel;
        logic [63:0] data;
        logic [7:0]  ru;
        logic [2:0]  iu;
        logic [7:0]  rs;
        logic [2:0]  isg;
    } vec_t;

    exp_t sb_q[$];
    int   pop_cyc[$];
    vec_t vecs[7];

    mms_tree_pipe #(.WIDTH(W), .NUM(N), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_select(in_select), .in_data(in_data), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_result(out_result_u), .out_index(out_index_u),
        .out_select(out_select_u)
    );

    mms_tree_pipe #(.WIDTH(W), .NUM(N), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_select(in_select), .in_data(in_data), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_result(out_result_s), .out_index(out_index_s),
        .out_select(out_select_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int opval(input logic [63:0] d, input int i, input bit sgn);
        logic [7:0] b;
        b = d[i*8 +: 8];
        if (sgn) return int'($signed(b));
        return int'(b);
    endfunction

    // Reference: linear scan, first occurrence of the strict extreme.
    function automatic int ref_idx(input logic [63:0] d, input logic sel, input bit sgn);
        int best = 0;
        for (int i = 1; i < N; i++) begin
            if (sel == 1'b0 && opval(d, i, sgn) > opval(d, best, sgn)) best = i;
            if (sel == 1'b1 && opval(d, i, sgn) < opval(d, best, sgn)) best = i;
        end
        return best;
    endfunction

    function automatic exp_t model(input logic [63:0] d, input logic sel);
        exp_t e;
        int iu, is;
        iu = ref_idx(d, sel, 1'b0);
        is = ref_idx(d, sel, 1'b1);
        e.sel = sel;
        e.iu  = 3'(iu);
        e.ru  = d[iu*8 +: 8];
        e.isg = 3'(is);
        e.rs  = d[is*8 +: 8];
        return e;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rst_n) begin
            chk("in_ready_match", in_ready_s, in_ready_u);
            if (out_valid_u && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_valid_s", out_valid_s, 1'b1);
                    chk("sb_result_u", out_result_u, e.ru);
                    chk("sb_index_u", out_index_u, e.iu);
                    chk("sb_result_s", out_result_s, e.rs);
                    chk("sb_index_s", out_index_s, e.isg);
                    chk("sb_select", out_select_u, e.sel);
                    chk("sb_select_s", out_select_s, e.sel);
                end
                out_cnt++;
                pop_cyc.push_back(cyc);
            end
            if (in_valid && in_ready_u) begin
                sb_q.push_back(model(in_data, in_select));
                in_cnt++;
            end
        end
    end

    task automatic drive_rand(input logic v);
        in_valid  = v;
        in_select = 1'($urandom_range(0, 1));
        in_data   = {$urandom, $urandom};
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid_u"}, out_valid_u, 1'b0);
        chk({tag, "_valid_s"}, out_valid_s, 1'b0);
        chk({tag, "_result"}, out_result_u, 8'h00);
        chk({tag, "_index"}, out_index_u, 3'd0);
        chk({tag, "_select"}, out_select_u, 1'b0);
        chk({tag, "_result_s"}, out_result_s, 8'h00);
        chk({tag, "_ready"}, in_ready_u, 1'b1);
    endtask

    initial begin
        logic [7:0] snap_r;
        logic [2:0] snap_i;
        logic       snap_s;
        int         base;

        vecs[0] = '{1'b0, 64'h05_00_01_C8_07_C8_09_03, 8'd200, 3'd2, 8'd9,   3'd1};
        vecs[1] = '{1'b1, 64'h05_00_01_C8_07_C8_09_03, 8'd0,   3'd6, 8'hC8,  3'd2};
        vecs[2] = '{1'b0, 64'h55_55_55_55_55_55_55_55, 8'h55,  3'd0, 8'h55,  3'd0};
        vecs[3] = '{1'b1, 64'h55_55_55_55_55_55_55_55, 8'h55,  3'd0, 8'h55,  3'd0};
        vecs[4] = '{1'b0, 64'h00_00_00_00_00_7F_FF_80, 8'hFF,  3'd1, 8'h7F,  3'd2};
        vecs[5] = '{1'b1, 64'h00_00_00_00_00_7F_FF_80, 8'h00,  3'd3, 8'h80,  3'd0};
        vecs[6] = '{1'b0, 64'hFF_00_00_00_00_00_00_00, 8'hFF,  3'd7, 8'h00,  3'd0};

        // Reset state
        #2;
        check_idle("reset");
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with exact latency
        out_ready = 1'b1;
        foreach (vecs[n]) begin
            in_valid  = 1'b1;
            in_select = vecs[n].sel;
            in_data   = vecs[n].data;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("vec_early_valid", out_valid_u, 1'b0);
            @(posedge clk);
            @(negedge clk);
            chk("vec_valid", out_valid_u, 1'b1);
            chk("vec_result_u", out_result_u, vecs[n].ru);
            chk("vec_index_u", out_index_u, vecs[n].iu);
            chk("vec_result_s", out_result_s, vecs[n].rs);
            chk("vec_index_s", out_index_s, vecs[n].isg);
            chk("vec_select", out_select_u, vecs[n].sel);
            @(posedge clk); #1;
        end

        // Back-to-back sets, alternating select
        mon_en = 1'b1;
        pop_cyc.delete();
        base = out_cnt;
        for (int i = 0; i < 10; i++) begin
            drive_rand(1'b1);
            in_select = 1'(i % 2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_count", 64'(out_cnt - base), 64'd10);
        if (pop_cyc.size() == 10)
            chk("b2b_consecutive", 64'(pop_cyc[9] - pop_cyc[0]), 64'd9);
        else
            chk("b2b_popcount", 64'(pop_cyc.size()), 64'd10);

        // Output stall for 4 cycles
        repeat (5) begin
            drive_rand(1'b1);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        drive_rand(1'b1);
        @(negedge clk);
        snap_r = out_result_u;
        snap_i = out_index_u;
        snap_s = out_select_u;
        chk("stall_valid0", out_valid_u, 1'b1);
        chk("stall_ready0", in_ready_u, 1'b0);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", out_valid_u, 1'b1);
            chk("stall_ready", in_ready_u, 1'b0);
            chk("stall_result", out_result_u, snap_r);
            chk("stall_index", out_index_u, snap_i);
            chk("stall_select", out_select_u, snap_s);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) begin
            drive_rand(1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("stall_drained", 64'(sb_q.size()), 64'd0);
        chk("stall_balance", 64'(in_cnt), 64'(out_cnt));

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            drive_rand(1'($urandom_range(0, 3) != 0));
            out_ready = 1'($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rand_drained", 64'(sb_q.size()), 64'd0);
        chk("rand_balance", 64'(in_cnt), 64'(out_cnt));

        // Reset mid-stream with three sets in flight
        mon_en = 1'b0;
        repeat (3) begin
            drive_rand(1'b1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("inflight_valid", out_valid_u, 1'b1);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle("midreset");
        sb_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", in_ready_u, 1'b1);
        in_valid  = 1'b1;
        in_select = vecs[0].sel;
        in_data   = vecs[0].data;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_empty1", out_valid_u, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_empty2", out_valid_u, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_valid", out_valid_u, 1'b1);
        chk("post_reset_result", out_result_u, vecs[0].ru);
        chk("post_reset_index", out_index_u, vecs[0].iu);
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_alone", out_valid_u, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
